pipelined_cla_addsub: RTL and testbench

//  Parametrised two-stage pipelined carry-lookahead adder/subtractor.

---
 rtl/pipelined_cla_addsub.sv | 160 ++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// Two-stage WIDTH-bit carry-lookahead adder/subtractor with valid/ready.
// Optional: define SATURATE_EN to clamp s to the signed limit on overflow.
`timescale 1ns/1ps
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  logic ld1, ld2;
  logic v1_q, v1_d;
  logic v2_q, v2_d;

  logic [WIDTH-1:0] b_eff, pb, gb;
  logic             c0;
  logic [NG-1:0]    pg, gg;
  logic [NG:0]      gc;
  // Only the lower GROUP-1 generates of a group feed in-group carries;
  // the group's top generate is already folded into the group carries.
  logic [NG-1:0][GROUP-2:0] gl;

  logic [WIDTH-1:0]         p1_q;
  logic [NG-1:0][GROUP-2:0] gl1_q;
  logic [NG-1:0]            gc1_q;
  logic                     co1_q, am1_q, bm1_q;

  logic [WIDTH-1:0] sum, s_d, s_q;
  logic             ovf_d;
  logic             cout_q, ovf_q, zero_q;

  assign ld2      = !v2_q || out_ready;
  assign ld1      = !v1_q || ld2;
  assign in_ready = ld1;
  assign v1_d     = ld1 ? in_valid : v1_q;
  assign v2_d     = ld2 ? v1_q : v2_q;

  always_comb begin : grp_pg
    logic pa, ga;
    pa    = 1'b1;
    ga    = 1'b0;
    b_eff = sub ? ~b : b;
    c0    = sub | cin;
    pb    = a ^ b_eff;
    gb    = a & b_eff;
    pg    = '0;
    gg    = '0;
    gl    = '0;
    for (int k = 0; k < NG; k++) begin
      pa = 1'b1;
      ga = 1'b0;
      for (int i = GROUP - 1; i >= 0; i--) begin
        ga = ga | (pa & gb[k*GROUP+i]);
        pa = pa & pb[k*GROUP+i];
      end
      pg[k] = pa;
      gg[k] = ga;
      for (int j = 0; j < GROUP - 1; j++)
        gl[k][j] = gb[k*GROUP+j];
    end
  end

  // Second-level lookahead: flat sum of products over group P/G.
  always_comb begin : grp_carry
    logic pa, ca;
    pa = 1'b1;
    ca = 1'b0;
    gc = '0;
    for (int k = 0; k <= NG; k++) begin
      pa = 1'b1;
      ca = 1'b0;
      for (int j = k - 1; j >= 0; j--) begin
        ca = ca | (pa & gg[j]);
        pa = pa & pg[j];
      end
      gc[k] = ca | (pa & c0);
    end
  end

  always_comb begin : bit_carry
    logic pa, ca;
    pa  = 1'b1;
    ca  = 1'b0;
    sum = '0;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        pa = 1'b1;
        ca = 1'b0;
        for (int j = i - 1; j >= 0; j--) begin
          ca = ca | (pa & gl1_q[k][j]);
          pa = pa & p1_q[k*GROUP+j];
        end
        ca = ca | (pa & gc1_q[k]);
        sum[k*GROUP+i] = p1_q[k*GROUP+i] ^ ca;
      end
    end
    ovf_d = (am1_q == bm1_q) && (sum[MSB] != am1_q);
    s_d   = sum;
`ifdef SATURATE_EN
    if (ovf_d)
      s_d = am1_q ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      p1_q   <= '0;
      gl1_q  <= '0;
      gc1_q  <= '0;
      co1_q  <= 1'b0;
      am1_q  <= 1'b0;
      bm1_q  <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (ld1 && in_valid) begin
        p1_q  <= pb;
        gl1_q <= gl;
        gc1_q <= gc[NG-1:0];
        co1_q <= gc[NG];
        am1_q <= a[MSB];
        bm1_q <= b_eff[MSB];
      end
      if (ld2 && v1_q) begin
        s_q    <= s_d;
        cout_q <= co1_q;
        ovf_q  <= ovf_d;
        zero_q <= ~|s_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub (WIDTH=16, GROUP=4): directed table,
// backpressure sequence, random stream with a mid-stream reset.
`timescale 1ns/1ps
module tb_pipelined_cla_addsub;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, sub;
  logic        out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, s;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov, z;
    logic [15:0] ss;
    logic        zs;
  } vec_t;

  vec_t tab [12];
  vec_t bp  [4];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Reference: plain WIDTH+1 bit arithmetic, {s, cout, ovf, zero}.
  function automatic logic [18:0] model(input logic [15:0] ma,
      input logic [15:0] mb, input logic mcin, input logic msub);
    logic [15:0] be, r;
    logic [16:0] t;
    logic        o;
    be = msub ? ~mb : mb;
    t  = {1'b0, ma} + {1'b0, be} + {16'h0, (msub ? 1'b1 : mcin)};
    o  = (ma[15] == be[15]) && (t[15] != ma[15]);
    r  = t[15:0];
`ifdef SATURATE_EN
    if (o) r = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {r, t[16], o, (r == 16'h0)};
  endfunction

  initial begin
    logic [18:0] q[$];
    logic [18:0] e;
    logic        acc, emit;
    int          sent, got;

    tab[0]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0, 16'h5556, 1'b0};
    tab[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
    tab[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'hFFFE, 1'b0};
    tab[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b0};
    tab[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 16'h8000, 1'b0};
    tab[5]  = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
    tab[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0};
    tab[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b0};
    tab[8]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0};
    tab[9]  = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
    tab[10] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
    tab[11] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b0};

    bp[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0};
    bp[1] = '{16'h1000, 16'h1000, 1'b0, 1'b0, 16'h2000, 1'b0, 1'b0, 1'b0, 16'h2000, 1'b0};
    bp[2] = '{16'hFFFF, 16'h0002, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    bp[3] = '{16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0, 1'b0, 16'h0006, 1'b0};

    // Reset held 3 cycles with a beat offered
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst s", s, 0);
    chk("rst flags", {cout, ovf, zero}, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst in_ready", in_ready, 1);

    // Directed table: one beat at a time, exact 2-edge latency
    for (int i = 0; i < 12; i++) begin
      a = tab[i].a; b = tab[i].b; cin = tab[i].cin; sub = tab[i].sub;
      in_valid = 1'b1;
      #1;
      chk("tab in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("tab early out_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("tab out_valid", out_valid, 1);
`ifdef SATURATE_EN
      chk("tab s", s, tab[i].ss);
      chk("tab zero", zero, tab[i].zs);
`else
      chk("tab s", s, tab[i].s);
      chk("tab zero", zero, tab[i].z);
`endif
      chk("tab cout", cout, tab[i].co);
      chk("tab ovf", ovf, tab[i].ov);
    end

    // Drain last table beat, then backpressure sequence
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      out_ready = (cyc >= 3);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        a = bp[sent].a; b = bp[sent].b;
        cin = bp[sent].cin; sub = bp[sent].sub;
      end
      #1;
      if (cyc == 1) chk("bp in_ready one full", in_ready, 1);
      if (cyc == 2) begin
        chk("bp in_ready both full", in_ready, 0);
        chk("bp stall out_valid", out_valid, 1);
        chk("bp stall s", s, bp[0].s);
      end
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        chk("bp beat s", s, bp[got].s);
        chk("bp beat cout", cout, bp[got].co);
        got++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    chk("bp delivered", got, 4);
    chk("bp no duplicate", out_valid, 0);

    // Random stream with random stalls and a mid-stream reset
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n     = (cyc != 300);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      #1;
      acc  = rst_n && in_valid && in_ready;
      emit = rst_n && out_valid && out_ready;
      if (emit) begin
        if (q.size() == 0) chk("rand extra beat", emit, 0);
        else begin
          e = q.pop_front();
          chk("rand beat", {s, cout, ovf, zero}, e);
        end
      end
      if (acc) q.push_back(model(a, b, cin, sub));
      @(posedge clk); #1;
      if (cyc == 300) begin
        q.delete();
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
      end
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("drain extra beat", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("drain beat", {s, cout, ovf, zero}, e);
        end
      end
      @(posedge clk); #1;
    end
    chk("rand all delivered", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
